// File: rtl/output_serializer.sv
// Parallel-to-serial pad driver: WIDTH-bit words shifted out LSB-first on OQ, TQ=0 while driving.
// Latency: handshake at edge t0 puts bit0 on OQ after t1; bit k after t1+k.
// Backpressure: one-word holding register; D_READY drops while it is full, so the stream is gapless.
module output_serializer #(
    parameter int   WIDTH   = 4,
    parameter logic INIT_OQ = 1'b0,
    parameter logic IDLE_TQ = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic             OQ,
    output logic             TQ,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_vld;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    logic last_bit;
    logic load;
    logic handshake;

    // Ready depends only on registers and reset, never on D_VALID.
    assign D_READY   = RST_N && !hold_vld;
    assign handshake = D_VALID && D_READY;
    assign last_bit  = (state == SHIFT) && (cnt == CW'(WIDTH));
    assign load      = hold_vld && ((state == IDLE) || last_bit);
    assign BUSY      = (state == SHIFT);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            hold     <= '0;
            hold_vld <= 1'b0;
            sr       <= '0;
            cnt      <= '0;
            OQ       <= INIT_OQ;
            TQ       <= IDLE_TQ;
        end else begin
            // A handshake can never coincide with a load: a full holding register blocks D_READY.
            if (handshake) begin
                hold     <= D;
                hold_vld <= 1'b1;
            end

            if (load) begin
                OQ       <= hold[0];
                sr       <= hold >> 1;
                cnt      <= CW'(1);
                TQ       <= 1'b0;
                state    <= SHIFT;
                hold_vld <= 1'b0;
            end else if (state == SHIFT) begin
                if (!last_bit) begin
                    OQ  <= sr[0];
                    sr  <= sr >> 1;
                    cnt <= cnt + CW'(1);
                end else begin
                    // Underrun: nothing queued behind the last bit, release the pad.
                    state <= IDLE;
                    OQ    <= INIT_OQ;
                    TQ    <= IDLE_TQ;
                    cnt   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: WIDTH=4 instance for the main cases, WIDTH=2 for the boundary.
module tb_output_serializer;

    logic       clk;
    logic       rst_n;
    logic [3:0] d4;
    logic       dv4;
    logic       rdy4, oq4, tq4, busy4;
    logic [1:0] d2;
    logic       dv2;
    logic       rdy2, oq2, tq2, busy2;

    int n_chk  = 0;
    int n_pass = 0;

    output_serializer #(.WIDTH(4), .INIT_OQ(1'b0), .IDLE_TQ(1'b1)) u_dut4 (
        .CLK     (clk),
        .RST_N   (rst_n),
        .D       (d4),
        .D_VALID (dv4),
        .D_READY (rdy4),
        .OQ      (oq4),
        .TQ      (tq4),
        .BUSY    (busy4)
    );

    output_serializer #(.WIDTH(2), .INIT_OQ(1'b0), .IDLE_TQ(1'b1)) u_dut2 (
        .CLK     (clk),
        .RST_N   (rst_n),
        .D       (d2),
        .D_VALID (dv2),
        .D_READY (rdy2),
        .OQ      (oq2),
        .TQ      (tq2),
        .BUSY    (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Advance one rising edge and settle past it so outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4_idle(input string tag);
        check({tag, ".oq"},   32'(oq4),   32'(0));
        check({tag, ".tq"},   32'(tq4),   32'(1));
        check({tag, ".busy"}, 32'(busy4), 32'(0));
    endtask

    initial begin
        logic [3:0] wa, wb, wc, w1;
        logic       exp_bits [12];
        logic       exp_rdy  [12];
        logic [1:0] v0, v1, v2;
        logic       exp2_bits [6];
        logic       exp2_rdy  [6];

        rst_n = 1'b0;
        d4 = 4'hF; dv4 = 1'b1;
        d2 = 2'b11; dv2 = 1'b1;

        // Reset held for 3 edges with D_VALID asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check4_idle("rst");
            check("rst.rdy4", 32'(rdy4), 32'(0));
            check("rst.rdy2", 32'(rdy2), 32'(0));
        end
        dv4 = 1'b0; dv2 = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel.rdy", 32'(rdy4), 32'(1));
        tick();
        check4_idle("rel");
        check("rel.rdy_after", 32'(rdy4), 32'(1));

        // Single word 4'b1011.
        w1 = 4'b1011;
        d4 = w1; dv4 = 1'b1;
        tick();
        dv4 = 1'b0; d4 = 4'h0;
        check("single.rdy_full", 32'(rdy4), 32'(0));
        check("single.busy_t0",  32'(busy4), 32'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("single.oq%0d", k), 32'(oq4), 32'(w1[k]));
            check($sformatf("single.tq%0d", k), 32'(tq4), 32'(0));
            check($sformatf("single.busy%0d", k), 32'(busy4), 32'(1));
        end
        tick();
        check4_idle("single.end");

        // Back-to-back A, 5, then 6 presented under backpressure.
        wa = 4'hA; wb = 4'h5; wc = 4'h6;
        for (int i = 0; i < 4; i++) begin
            exp_bits[i]     = wa[i];
            exp_bits[4 + i] = wb[i];
            exp_bits[8 + i] = wc[i];
        end
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        d4 = wa; dv4 = 1'b1;
        tick();
        d4 = wb;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("b2b.oq%0d", c),  32'(oq4),   32'(exp_bits[c-1]));
            check($sformatf("b2b.tq%0d", c),  32'(tq4),   32'(0));
            check($sformatf("b2b.rdy%0d", c), 32'(rdy4),  32'(exp_rdy[c-1]));
            if (c == 2) d4 = wc;
            if (c == 6) begin
                dv4 = 1'b0;
                d4  = 4'hF;
            end
        end
        tick();
        check4_idle("b2b.end");

        // Reset mid-word: bit1 of 4'hF on OQ with 4'h3 held.
        d4 = 4'hF; dv4 = 1'b1;
        tick();
        d4 = 4'h3;
        tick();
        tick();
        dv4 = 1'b0;
        check("midrst.oq_bit1", 32'(oq4),  32'(1));
        check("midrst.held",    32'(rdy4), 32'(0));
        rst_n = 1'b0;
        tick();
        check4_idle("midrst");
        check("midrst.rdy_low", 32'(rdy4), 32'(0));
        rst_n = 1'b1;
        #1;
        check("midrst.hold_clr", 32'(rdy4), 32'(1));
        for (int i = 0; i < 6; i++) begin
            tick();
            check4_idle($sformatf("midrst.after%0d", i));
        end

        // WIDTH=2 continuous words 01, 10, 11.
        v0 = 2'b01; v1 = 2'b10; v2 = 2'b11;
        exp2_bits = '{v0[0], v0[1], v1[0], v1[1], v2[0], v2[1]};
        exp2_rdy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        d2 = v0; dv2 = 1'b1;
        tick();
        d2 = v1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("w2.oq%0d", c),   32'(oq2),   32'(exp2_bits[c-1]));
            check($sformatf("w2.tq%0d", c),   32'(tq2),   32'(0));
            check($sformatf("w2.busy%0d", c), 32'(busy2), 32'(1));
            check($sformatf("w2.rdy%0d", c),  32'(rdy2),  32'(exp2_rdy[c-1]));
            if (c == 2) d2 = v2;
            if (c == 4) dv2 = 1'b0;
        end
        tick();
        check("w2.end.oq",   32'(oq2),   32'(0));
        check("w2.end.tq",   32'(tq2),   32'(1));
        check("w2.end.busy", 32'(busy2), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
